// File: rtl/wfq_egress_reader.sv
// Drain-side reader for the WFQ egress buffer: issues spaced read requests, captures
// the returned word after a fixed latency, and keeps saturating per-flow/total counters.
module wfq_egress_reader #(
    parameter int NUM_FLOWS  = 16,
    parameter int FLOW_W     = 4,
    parameter int DATA_W     = 64,
    parameter int RD_LATENCY = 7,
    parameter int GAP_CYCLES = 11,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              in_packet_buffer_empty,
    input  logic [DATA_W-1:0] in_packet_data_out,
    output logic              out_rd_packet_req,
    output logic              out_word_valid,
    output logic [DATA_W-1:0] out_word_data,
    output logic [FLOW_W-1:0] out_word_flow,
    input  logic              in_clear_counts,
    input  logic [FLOW_W-1:0] in_cnt_sel,
    output logic [CNT_W-1:0]  out_cnt_value,
    output logic [CNT_W-1:0]  out_total_count,
    output logic              out_err_unknown_flow,
    output logic              out_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_CAPTURE,
        S_GAP
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [5:0]        r_lat_cnt;
    logic [7:0]        r_gap_cnt;
    logic              r_rd_req;
    logic              r_word_valid;
    logic [DATA_W-1:0] r_word_data;
    logic [FLOW_W-1:0] r_word_flow;
    logic              r_err;
    logic [CNT_W-1:0]  r_total;
    logic [CNT_W-1:0]  r_cnt_value;

    logic              w_capture;
    logic              w_known;
    logic              w_count_en;
    logic [FLOW_W-1:0] w_in_flow;
    logic [CNT_W-1:0]  w_cnt_pad [2**FLOW_W];

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (enable && !in_packet_buffer_empty) w_state_next = S_REQ;
            S_REQ:     w_state_next = (RD_LATENCY == 1) ? S_CAPTURE : S_WAIT;
            S_WAIT:    if (r_lat_cnt <= 6'd1) w_state_next = S_CAPTURE;
            S_CAPTURE: w_state_next = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
            S_GAP:     if (r_gap_cnt <= 8'd1) w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    // The request flop is loaded from the next state so it is high exactly during REQ.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_lat_cnt <= 6'd0;
            r_gap_cnt <= 8'd0;
            r_rd_req  <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_rd_req <= (w_state_next == S_REQ);
            case (r_state)
                S_REQ:     r_lat_cnt <= 6'(RD_LATENCY - 1);
                S_WAIT:    r_lat_cnt <= r_lat_cnt - 6'd1;
                S_CAPTURE: r_gap_cnt <= 8'(GAP_CYCLES);
                S_GAP:     r_gap_cnt <= r_gap_cnt - 8'd1;
                default:   ;
            endcase
        end
    end

    assign w_capture  = (r_state == S_CAPTURE);
    assign w_known    = (in_packet_data_out < DATA_W'(NUM_FLOWS));
    assign w_in_flow  = in_packet_data_out[FLOW_W-1:0];
    assign w_count_en = w_capture && w_known && !in_clear_counts;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_word_valid <= 1'b0;
            r_word_data  <= '0;
            r_word_flow  <= '0;
            r_err        <= 1'b0;
        end else begin
            r_word_valid <= w_capture;
            if (w_capture) begin
                r_word_data <= in_packet_data_out;
                r_word_flow <= w_in_flow;
            end
            if (in_clear_counts)
                r_err <= 1'b0;
            else if (w_capture && !w_known)
                r_err <= 1'b1;
        end
    end

    // Unused select codes beyond NUM_FLOWS read back as zero through the padded view.
    genvar gi;
    generate
        for (gi = 0; gi < 2**FLOW_W; gi++) begin : g_flow
            if (gi < NUM_FLOWS) begin : g_cnt
                logic [CNT_W-1:0] r_cnt;
                always_ff @(posedge clk) begin
                    if (!rst || in_clear_counts)
                        r_cnt <= '0;
                    else if (w_count_en && (w_in_flow == FLOW_W'(gi)) && (r_cnt != '1))
                        r_cnt <= r_cnt + CNT_W'(1);
                end
                assign w_cnt_pad[gi] = r_cnt;
            end else begin : g_pad
                assign w_cnt_pad[gi] = '0;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst || in_clear_counts)
            r_total <= '0;
        else if (w_count_en && (r_total != '1))
            r_total <= r_total + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst)
            r_cnt_value <= '0;
        else
            r_cnt_value <= w_cnt_pad[in_cnt_sel];
    end

    assign out_rd_packet_req    = r_rd_req;
    assign out_word_valid       = r_word_valid;
    assign out_word_data        = r_word_data;
    assign out_word_flow        = r_word_flow;
    assign out_cnt_value        = r_cnt_value;
    assign out_total_count      = r_total;
    assign out_err_unknown_flow = r_err;
    assign out_busy             = (r_state != S_IDLE);

endmodule

// File: tb/tb_wfq_egress_reader.sv
// Scoreboard bench for wfq_egress_reader: default instance for function/timing,
// a second small-counter instance (latency 1, no gap) for saturation.
module tb_wfq_egress_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // default-parameter instance
    logic        rst, enable, empty, clear;
    logic [63:0] data;
    logic [3:0]  sel;
    logic        req, valid, err, busy;
    logic [63:0] wdata;
    logic [3:0]  wflow;
    logic [31:0] cnt_value, total;

    // small-counter instance
    logic        en_2, empty_2, clear_2;
    logic [63:0] data_2;
    logic [3:0]  sel_2;
    logic        req_2, valid_2, err_2, busy_2;
    logic [63:0] wdata_2;
    logic [3:0]  wflow_2;
    logic [3:0]  cnt_value_2, total_2;

    wfq_egress_reader dut (
        .clk(clk), .rst(rst), .enable(enable),
        .in_packet_buffer_empty(empty), .in_packet_data_out(data),
        .out_rd_packet_req(req), .out_word_valid(valid),
        .out_word_data(wdata), .out_word_flow(wflow),
        .in_clear_counts(clear), .in_cnt_sel(sel),
        .out_cnt_value(cnt_value), .out_total_count(total),
        .out_err_unknown_flow(err), .out_busy(busy)
    );

    wfq_egress_reader #(.RD_LATENCY(1), .GAP_CYCLES(0), .CNT_W(4)) dut_2 (
        .clk(clk), .rst(rst), .enable(en_2),
        .in_packet_buffer_empty(empty_2), .in_packet_data_out(data_2),
        .out_rd_packet_req(req_2), .out_word_valid(valid_2),
        .out_word_data(wdata_2), .out_word_flow(wflow_2),
        .in_clear_counts(clear_2), .in_cnt_sel(sel_2),
        .out_cnt_value(cnt_value_2), .out_total_count(total_2),
        .out_err_unknown_flow(err_2), .out_busy(busy_2)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] sb_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst && valid) begin
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 64'd1, 64'd0);
            end else begin
                $display("word @%0d: data=%0h flow=%0d exp=%0h", cyc, wdata, wflow, sb_q[0]);
                chk("word_data", wdata, sb_q[0]);
                chk("word_flow", 64'(wflow), 64'(sb_q[0][3:0]));
                void'(sb_q.pop_front());
            end
        end
    end

    task automatic wait_req(output int unsigned c);
        bit got;
        got = 0;
        c = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req) begin
                c = cyc;
                got = 1;
                break;
            end
        end
        if (!got) chk("req_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_valid(output int unsigned c);
        bit got;
        got = 0;
        c = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (valid) begin
                c = cyc;
                got = 1;
                break;
            end
        end
        if (!got) chk("valid_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_word(input logic [63:0] v, output int unsigned rq, output int unsigned lat);
        int unsigned vc;
        data = v;
        wait_req(rq);
        sb_q.push_back(v);
        wait_valid(vc);
        lat = vc - rq;
    endtask

    task automatic read_cnt(input logic [3:0] s, input logic [31:0] exp, input string tag);
        sel = s;
        @(negedge clk);
        chk(tag, 64'(cnt_value), 64'(exp));
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk("busy_idle", 64'(busy), 64'd0);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned t0, rq, prev_rq, lat, vc;
        int bad_lat, n_req, n_busy, n_valid, n2;

        rst = 1'b0; enable = 1'b0; empty = 1'b0; clear = 1'b0; data = 64'd5; sel = 4'd5;
        en_2 = 1'b0; empty_2 = 1'b0; clear_2 = 1'b0; data_2 = 64'd1; sel_2 = 4'd1;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_req", 64'(req), 64'd0);
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_total", 64'(total), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_cnt", 64'(cnt_value), 64'd0);
        chk("rst_wdata", wdata, 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // four flow-5 words: first-request delay, latency, spacing
        enable = 1'b1;
        t0 = cyc;
        do_word(64'd5, rq, lat);
        chk("first_req_delay", 64'(rq - t0), 64'd1);
        chk("capture_latency", 64'(lat), 64'd8);
        for (int k = 0; k < 3; k++) begin
            prev_rq = rq;
            do_word(64'd5, rq, lat);
            chk("req_spacing", 64'(rq - prev_rq), 64'd20);
            chk("capture_latency", 64'(lat), 64'd8);
        end
        enable = 1'b0;
        wait_idle();
        chk("t1_total", 64'(total), 64'd4);
        read_cnt(4'd5, 32'd4, "t1_cnt5");
        read_cnt(4'd4, 32'd0, "t1_cnt4");

        // all flows, 8 rounds
        pulse_clear();
        enable = 1'b1;
        bad_lat = 0;
        for (int r = 0; r < 8; r++)
            for (int i = 0; i < 16; i++) begin
                do_word(64'(i), rq, lat);
                if (lat != 8) bad_lat++;
            end
        enable = 1'b0;
        wait_idle();
        chk("t2_bad_latency", 64'(bad_lat), 64'd0);
        chk("t2_total", 64'(total), 64'd128);
        chk("t2_err", 64'(err), 64'd0);
        for (int i = 0; i < 16; i++) read_cnt(4'(i), 32'd8, "t2_cnt");

        // unknown flows
        pulse_clear();
        chk("t3_total_cleared", 64'(total), 64'd0);
        enable = 1'b1;
        do_word(64'd16, rq, lat);
        chk("t3_err_after_16", 64'(err), 64'd1);
        chk("t3_total_16", 64'(total), 64'd0);
        do_word(64'hFFFF_FFFF_FFFF_FFFF, rq, lat);
        enable = 1'b0;
        wait_idle();
        chk("t3_err_hold", 64'(err), 64'd1);
        chk("t3_total", 64'(total), 64'd0);
        read_cnt(4'd0, 32'd0, "t3_cnt0");
        read_cnt(4'd15, 32'd0, "t3_cnt15");
        pulse_clear();
        chk("t3_err_cleared", 64'(err), 64'd0);

        // clear on the capture edge of a flow-3 word
        enable = 1'b1;
        do_word(64'd3, rq, lat);
        chk("t4_total_pre", 64'(total), 64'd1);
        data = 64'd3;
        wait_req(rq);
        sb_q.push_back(64'd3);
        repeat (7) @(negedge clk);
        clear = 1'b1;
        wait_valid(vc);
        clear = 1'b0;
        enable = 1'b0;
        chk("t4_latency", 64'(vc - rq), 64'd8);
        chk("t4_total", 64'(total), 64'd0);
        read_cnt(4'd3, 32'd0, "t4_cnt3");
        wait_idle();

        // empty buffer, then enable dropped during WAIT
        empty = 1'b1;
        enable = 1'b1;
        n_req = 0; n_busy = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (req) n_req++;
            if (busy) n_busy++;
        end
        chk("t5_empty_reqs", 64'(n_req), 64'd0);
        chk("t5_empty_busy", 64'(n_busy), 64'd0);
        data = 64'd7;
        empty = 1'b0;
        wait_req(rq);
        sb_q.push_back(64'd7);
        repeat (2) @(negedge clk);
        enable = 1'b0;
        wait_valid(vc);
        n_req = 0; n_valid = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (req) n_req++;
            if (valid) n_valid++;
        end
        chk("t5_after_reqs", 64'(n_req), 64'd0);
        chk("t5_after_valids", 64'(n_valid), 64'd0);
        chk("t5_total", 64'(total), 64'd1);
        read_cnt(4'd7, 32'd1, "t5_cnt7");

        // reset during WAIT drops the pending capture
        enable = 1'b1;
        data = 64'd9;
        wait_req(rq);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("t6_req", 64'(req), 64'd0);
        chk("t6_valid", 64'(valid), 64'd0);
        chk("t6_total", 64'(total), 64'd0);
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_cnt_value", 64'(cnt_value), 64'd0);
        n_valid = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (valid) n_valid++;
        end
        chk("t6_no_capture", 64'(n_valid), 64'd0);
        read_cnt(4'd7, 32'd0, "t6_cnt7");

        // 4-bit counter saturation on the second instance
        en_2 = 1'b1;
        n2 = 0;
        for (int i = 0; i < 300 && n2 < 20; i++) begin
            @(negedge clk);
            if (valid_2) n2++;
        end
        en_2 = 1'b0;
        repeat (5) @(negedge clk);
        chk("t7_words", 64'(n2), 64'd20);
        chk("t7_cnt1_sat", 64'(cnt_value_2), 64'd15);
        chk("t7_total_sat", 64'(total_2), 64'd15);
        chk("t7_data", wdata_2, 64'd1);
        chk("t7_err", 64'(err_2), 64'd0);

        chk("sb_leftover", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
